fan_sum_collector: RTL

Output-side collector for the carry-save forwarding adder network (FAN). It accepts one FAN result bundle per handshake: N-1 partial sums, their per-sum valid flags and the bundle's N vector IDs. It compacts the valid sums and streams them out one per cycle, in ascending sum index, each tagged with its vector ID. A two-slot bundle buffer lets the FAN deliver the next bundle while the current one drains.

---
 rtl/fan_pkg.sv | 25 ++
 rtl/fan_prio_enc.sv | 24 ++
 rtl/fan_sum_collector.sv | 89 ++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared sizing, slot storage layout and occupancy encoding for the FAN sum collector.
package fan_pkg;
    localparam int N_DEF = 16;
    localparam int W_DEF = 8;
    localparam int V_DEF = 3;

    // A sum of N operands of W bits needs log2(N) guard bits.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n);
    endfunction

    localparam int S_DEF = sum_width(N_DEF, W_DEF);

    typedef struct packed {
        logic [N_DEF-2:0][S_DEF-1:0] sums;
        logic [N_DEF-1:0][V_DEF-1:0] vec_ids;
        logic [N_DEF-2:0]            pending;
    } slot_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        ONE      = 2'd1,
        FULL_TWO = 2'd2
    } occ_t;
endpackage

// File: rtl/fan_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and exactly-one-bit flag; combinational.
// No handshake; outputs are zero when req is zero.
module fan_prio_enc #(
    parameter int M = 15
) (
    input  logic [M-1:0]         req,
    output logic [$clog2(M)-1:0] idx,
    output logic [M-1:0]         onehot,
    output logic                 single
);
    localparam int IW = $clog2(M);

    always_comb begin
        idx = '0;
        // Scanning downward lets the lowest set bit win.
        for (int i = M - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
        onehot = req & (~req + M'(1));
        single = (req != '0) && ((req & (req - M'(1))) == '0);
    end
endmodule

// File: rtl/fan_sum_collector.sv
// Compacts the valid sums of a FAN bundle and streams them one per cycle with their vector IDs.
// Latency: first result the cycle after acceptance; two bundle slots, in_ready from registered occupancy only.
module fan_sum_collector import fan_pkg::*; #(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    parameter int V = V_DEF,
    parameter int S = W + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-2:0][S-1:0]   in_sums,
    input  logic [N-2:0]          in_sum_valids,
    input  logic [N-1:0][V-1:0]   in_vec_ids,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [S-1:0]          out_sum,
    output logic [V-1:0]          out_vec_id,
    output logic                  out_last
);
    localparam int IW = $clog2(N - 1);
    localparam int VW = $clog2(N);

    slot_t            slots [2];
    occ_t             state;
    logic             head;
    logic             tail;
    logic [IW-1:0]    idx;
    logic [N-2:0]     onehot;
    logic             single;
    logic [VW-1:0]    vid_idx;
    logic             accept;
    logic             fire;
    logic             free;

    fan_prio_enc #(.M(N - 1)) u_prio_enc (
        .req    (slots[head].pending),
        .idx    (idx),
        .onehot (onehot),
        .single (single)
    );

    assign in_ready  = (state != FULL_TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign free      = fire && single;

    // Sum i closes the group whose last operand is i+1.
    assign vid_idx    = VW'(idx) + VW'(1);
    assign out_sum    = out_valid ? slots[head].sums[idx] : '0;
    assign out_vec_id = out_valid ? slots[head].vec_ids[vid_idx] : '0;
    assign out_last   = out_valid && single;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slots[i] <= '0;
            end
        end else begin
            // Head and tail never alias while both a fire and an accept can occur.
            if (fire) begin
                slots[head].pending <= slots[head].pending & ~onehot;
                if (single) begin
                    head <= ~head;
                end
            end
            if (accept) begin
                slots[tail].sums    <= in_sums;
                slots[tail].vec_ids <= in_vec_ids;
                slots[tail].pending <= in_sum_valids | {1'b1, {(N-2){1'b0}}};
                tail                <= ~tail;
            end
            case (state)
                EMPTY:    if (accept) state <= ONE;
                ONE: begin
                    if (accept && !free)      state <= FULL_TWO;
                    else if (free && !accept) state <= EMPTY;
                end
                FULL_TWO: if (free) state <= ONE;
                default:  state <= EMPTY;
            endcase
        end
    end
endmodule
